rx_os_checker_array: RTL
========================

// Module: rx_os_checker_array
// PURPOSE
// - Per-lane RX ordered-set checkers that feed the master RX LTSSM its per-lane "condition met" vector.
// - Each lane counts consecutive, identical, substate-appropriate TS1/TS2/IDLE sets. When the count reaches the
//   master's comparatorsCount, the lane raises its countersComparators bit.
// - Sits between the per-lane OS decoders (upstream) and the master RX LTSSM (downstream).
// PARAMETERS
// - MAXLANES  16  number of lane checker instances; all lane vectors are MAXLANES wide (or MAXLANES*8 when flattened)
// PORTS
// - clk                   in   1            rising-edge clock
// - reset                 in   1            asynchronous, active-low reset
// - substate              in   4            current LTSSM substate (shared package codes, detectQuiet=0..configurationIdle=9)
// - comparatorsCount      in   5            required consecutive-OS count from the master; 0 = never satisfied
// - resetOsCheckers       in   MAXLANES     per-lane active-low clear; 0 holds the lane cleared
// - numberOfDetectedLanes in   5            active lanes 1,2,4,8,16; lanes at index >= this are held cleared
// - osValid               in   MAXLANES     one-cycle strobe: a complete OS was decoded on lane i
// - osType                in   2*MAXLANES   lane i at [2i+1:2i]: 00 other, 01 TS1, 10 TS2, 11 IDLE
// - osLinkNum             in   8*MAXLANES   link number field of lane i at [8i+7:8i]
// - osLaneNum             in   8*MAXLANES   lane number field of lane i at [8i+7:8i]
// - countersComparators   out  MAXLANES     bit i = lane i satisfied
// - capturedLinkNum       out  8            link number stored by lane 0
// - capturedLaneNum       out  8*MAXLANES   lane number stored per lane
// BEHAVIOUR
// - Reset: all counts 0, stored link/lane 8'hF7 (PAD), countersComparators 0, captured outputs 8'hF7.
// - Per-lane state: cnt[4:0] saturating at 31; lastLink[7:0]; lastLane[7:0].
// - Expected OS and field rule per substate (match = type equal AND rule holds):
//     pollingActive                  TS1 or TS2, any fields
//     pollingConfiguration           TS2, any fields
//     configurationLinkWidthStart    TS1, link != PAD
//     configurationLinkWidthAccept   TS1, link != PAD, lane != PAD
//     configurationLanenumWait       TS1 or TS2, lane != PAD
//     configurationLanenumAccept     TS2, link != PAD, lane != PAD
//     configurationComplete          TS2, link != PAD, lane != PAD
//     configurationIdle              IDLE, fields ignored
//     detectQuiet, detectActive, other codes: nothing matches; cnt held at 0
// - On osValid[i] (rising edge N; result visible at N+1):
//     match AND (cnt==0 OR fields equal lastLink/lastLane)  -> cnt = sat(cnt+1); store fields
//     match AND fields differ                               -> cnt = 1; store new fields (consecutive-identical rule)
//     no match                                              -> cnt = 0; stored fields unchanged
// - No osValid: state holds.
// - Precedence per lane: reset > resetOsCheckers[i]==0 > lane inactive > osValid.
//   Clear sets cnt=0 and stored fields=PAD.
// - A substate change does not clear a lane; the master clears lanes via resetOsCheckers between requests.
// - countersComparators[i] = (comparatorsCount != 0) && (cnt >= comparatorsCount); registered path, 1 cycle after
//   the satisfying osValid.
// - Comparison is 5-bit unsigned; saturation at 31 must never wrap to 0.
// - If comparatorsCount changes mid-count, the bit re-evaluates on the next cycle with no count change.
// - capturedLinkNum = lane 0 lastLink; capturedLaneNum[i] = lane i lastLane.
// STRUCTURE
// - Shared package: substate codes (shared with the master RX LTSSM), OS type encodings, PAD = 8'hF7.
// - Sub-module rx_os_lane_counter: one lane's match logic, counter, field registers, comparator bit.
// - Top level: lane-active mask decode from numberOfDetectedLanes plus a generate loop of MAXLANES instances.
// TESTING
// - Reset, then 4 lanes active, substate=2, comparatorsCount=8, 8 TS1 strobes per lane
//   -> countersComparators=16'h000F one cycle after the 8th strobe, not before.
// - substate=5, count=2: TS1 link=5 lane=0, then TS1 link=6 lane=0 on lane 0 -> cnt=1, bit 0 stays 0;
//   a third TS1 link=6 -> bit 0 = 1.
// - substate=3, 7 TS2 then 1 TS1 then 8 TS2 on lane 0, count=8
//   -> bit 0 stays 0 until the 8th TS2 after the TS1.
// - resetOsCheckers[0]=0 for one cycle coincident with a matching osValid while cnt=7
//   -> cnt=0 and captured fields=PAD; the strobe is ignored.
// - numberOfDetectedLanes=2, all 16 lanes strobed with valid TS2 in substate 3 -> only bits [1:0] ever set.
// - 40 matching IDLE sets in substate 9, count=31 -> cnt saturates at 31 and bit 0 stays 1.
//   Then assert reset mid-stream -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/rx_os_checker_array_pkg.sv
// Shared definitions for the RX ordered-set checker array: LTSSM substate codes,
// ordered-set type encodings and the PAD symbol value.
package rx_os_checker_array_pkg;

  typedef enum logic [3:0] {
    DETECT_QUIET            = 4'd0,
    DETECT_ACTIVE           = 4'd1,
    POLLING_ACTIVE          = 4'd2,
    POLLING_CONFIGURATION   = 4'd3,
    CONFIG_LINKWIDTH_START  = 4'd4,
    CONFIG_LINKWIDTH_ACCEPT = 4'd5,
    CONFIG_LANENUM_WAIT     = 4'd6,
    CONFIG_LANENUM_ACCEPT   = 4'd7,
    CONFIG_COMPLETE         = 4'd8,
    CONFIG_IDLE             = 4'd9
  } substate_e;

  typedef enum logic [1:0] {
    OS_OTHER = 2'b00,
    OS_TS1   = 2'b01,
    OS_TS2   = 2'b10,
    OS_IDLE  = 2'b11
  } os_type_e;

  localparam logic [7:0] PAD     = 8'hF7;
  localparam logic [4:0] CNT_MAX = 5'd31;

  // Lanes below the detected-lane count are active; the rest are held cleared.
  function automatic logic lane_active(input int idx, input logic [4:0] num_lanes);
    return idx < int'({27'd0, num_lanes});
  endfunction

endpackage

// File: rtl/rx_os_checker_array_if.sv
// Bundle between the per-lane OS decoders / master RX LTSSM and the checker array.
// osValid is a one-cycle strobe per decoded ordered set; there is no backpressure, every strobe is consumed.
interface rx_os_checker_array_if #(parameter int MAXLANES = 16);

  logic [3:0]            substate;
  logic [4:0]            comparatorsCount;
  logic [MAXLANES-1:0]   resetOsCheckers;
  logic [4:0]            numberOfDetectedLanes;
  logic [MAXLANES-1:0]   osValid;
  logic [2*MAXLANES-1:0] osType;
  logic [8*MAXLANES-1:0] osLinkNum;
  logic [8*MAXLANES-1:0] osLaneNum;
  logic [MAXLANES-1:0]   countersComparators;
  logic [7:0]            capturedLinkNum;
  logic [8*MAXLANES-1:0] capturedLaneNum;

  modport master (
    output substate, comparatorsCount, resetOsCheckers, numberOfDetectedLanes,
           osValid, osType, osLinkNum, osLaneNum,
    input  countersComparators, capturedLinkNum, capturedLaneNum
  );

  modport slave (
    input  substate, comparatorsCount, resetOsCheckers, numberOfDetectedLanes,
           osValid, osType, osLinkNum, osLaneNum,
    output countersComparators, capturedLinkNum, capturedLaneNum
  );

endinterface

// File: rtl/rx_os_checker_array_lane_counter.sv
// One lane's checker: substate-dependent OS match, consecutive-identical counter,
// stored link/lane fields and the registered "count reached" bit.
module rx_os_lane_counter
  import rx_os_checker_array_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear_i,
  input  logic       valid_i,
  input  logic [3:0] substate_i,
  input  logic [4:0] count_req_i,
  input  logic [1:0] os_type_i,
  input  logic [7:0] link_i,
  input  logic [7:0] lane_i,
  output logic       cmp_o,
  output logic [7:0] link_o,
  output logic [7:0] lane_o
);

  logic [4:0] cnt_q, cnt_d;
  logic [7:0] link_q, link_d;
  logic [7:0] lane_q, lane_d;
  logic       cmp_q, cmp_d;
  logic       match;
  logic       same;
  logic       is_ts1, is_ts2, link_ok, lane_ok;

  assign is_ts1  = (os_type_i == OS_TS1);
  assign is_ts2  = (os_type_i == OS_TS2);
  assign link_ok = (link_i != PAD);
  assign lane_ok = (lane_i != PAD);

  always_comb begin
    match = 1'b0;
    case (substate_e'(substate_i))
      POLLING_ACTIVE:          match = is_ts1 || is_ts2;
      POLLING_CONFIGURATION:   match = is_ts2;
      CONFIG_LINKWIDTH_START:  match = is_ts1 && link_ok;
      CONFIG_LINKWIDTH_ACCEPT: match = is_ts1 && link_ok && lane_ok;
      CONFIG_LANENUM_WAIT:     match = (is_ts1 || is_ts2) && lane_ok;
      CONFIG_LANENUM_ACCEPT:   match = is_ts2 && link_ok && lane_ok;
      CONFIG_COMPLETE:         match = is_ts2 && link_ok && lane_ok;
      CONFIG_IDLE:             match = (os_type_i == OS_IDLE);
      default:                 match = 1'b0;
    endcase
  end

  // IDLE sets carry no meaningful fields, so they always count as identical.
  assign same = (substate_e'(substate_i) == CONFIG_IDLE) ||
                ((link_i == link_q) && (lane_i == lane_q));

  always_comb begin
    cnt_d  = cnt_q;
    link_d = link_q;
    lane_d = lane_q;
    if (clear_i) begin
      cnt_d  = '0;
      link_d = PAD;
      lane_d = PAD;
    end else if (valid_i) begin
      if (match) begin
        if ((cnt_q == '0) || same) begin
          cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 5'd1;
        end else begin
          cnt_d = 5'd1;
        end
        link_d = link_i;
        lane_d = lane_i;
      end else begin
        cnt_d = '0;
      end
    end
    cmp_d = (count_req_i != '0) && (cnt_d >= count_req_i);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      link_q <= PAD;
      lane_q <= PAD;
      cmp_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      link_q <= link_d;
      lane_q <= lane_d;
      cmp_q  <= cmp_d;
    end
  end

  assign cmp_o  = cmp_q;
  assign link_o = link_q;
  assign lane_o = lane_q;

endmodule

// File: rtl/rx_os_checker_array.sv
// Array of per-lane ordered-set checkers producing the master RX LTSSM's per-lane
// "condition met" vector plus the captured link/lane numbers.
module rx_os_checker_array
  import rx_os_checker_array_pkg::*;
#(
  parameter int MAXLANES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  rx_os_checker_array_if.slave bus
);

  logic [7:0] lane_link [MAXLANES];

  for (genvar i = 0; i < MAXLANES; i++) begin : g_lane
    logic clear;

    // Master clear and inactive lanes both hold the lane at its cleared state.
    assign clear = !bus.resetOsCheckers[i] || !lane_active(i, bus.numberOfDetectedLanes);

    rx_os_lane_counter u_lane (
      .clk         (clk),
      .reset       (reset),
      .clear_i     (clear),
      .valid_i     (bus.osValid[i]),
      .substate_i  (bus.substate),
      .count_req_i (bus.comparatorsCount),
      .os_type_i   (bus.osType[2*i +: 2]),
      .link_i      (bus.osLinkNum[8*i +: 8]),
      .lane_i      (bus.osLaneNum[8*i +: 8]),
      .cmp_o       (bus.countersComparators[i]),
      .link_o      (lane_link[i]),
      .lane_o      (bus.capturedLaneNum[8*i +: 8])
    );
  end

  assign bus.capturedLinkNum = lane_link[0];

endmodule
